// File: rtl/riscv_imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (head + skid register).
// Decodes I/S/B/U/J/SHAMT/ZIMM immediates and counts illegal-select beats.
module riscv_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr,
  input  logic [2:0]       i_imm_src,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_err,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [2:0] SRC_I     = 3'd0;
  localparam logic [2:0] SRC_S     = 3'd1;
  localparam logic [2:0] SRC_B     = 3'd2;
  localparam logic [2:0] SRC_U     = 3'd3;
  localparam logic [2:0] SRC_J     = 3'd4;
  localparam logic [2:0] SRC_SHAMT = 3'd5;
  localparam logic [2:0] SRC_ZIMM  = 3'd6;

  state_t           state;
  logic             ready_q;
  xlen_t            head_imm;
  logic             head_err;
  xlen_t            skid_imm;
  logic             skid_err;
  logic [CNT_W-1:0] err_cnt;

  xlen_t      dec_imm;
  logic       dec_err;
  logic [5:0] shamt;
  logic       accept;
  logic       unused_opcode_bits;

  assign unused_opcode_bits = ^i_instr[6:0];
  assign accept = i_valid && ready_q;

  // RV64 shifts use a 6-bit shift amount; RV32 keeps bit 25 out of it.
  assign shamt = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (i_imm_src)
      SRC_I:     dec_imm = xlen_t'($signed(i_instr[31:20]));
      SRC_S:     dec_imm = xlen_t'($signed({i_instr[31:25], i_instr[11:7]}));
      SRC_B:     dec_imm = xlen_t'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                            i_instr[11:8], 1'b0}));
      SRC_U:     dec_imm = xlen_t'($signed({i_instr[31:12], 12'b0}));
      SRC_J:     dec_imm = xlen_t'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                            i_instr[30:21], 1'b0}));
      SRC_SHAMT: dec_imm = xlen_t'(shamt);
      SRC_ZIMM:  dec_imm = xlen_t'(i_instr[19:15]);
      default:   dec_err = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data registers are reset too, so o_imm/o_err read zero during and right after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= EMPTY;
      ready_q  <= 1'b0;
      head_imm <= '0;
      head_err <= 1'b0;
      skid_imm <= '0;
      skid_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept && dec_err && !(&err_cnt))
        err_cnt <= err_cnt + 1'b1;

      // ready_q mirrors "next state is not FULL"; only the ONE->FULL branch and a stalled FULL clear it.
      ready_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            state    <= ONE;
            head_imm <= dec_imm;
            head_err <= dec_err;
          end
        end
        ONE: begin
          if (accept && !i_ready) begin
            state    <= FULL;
            skid_imm <= dec_imm;
            skid_err <= dec_err;
            ready_q  <= 1'b0;
          end else if (accept) begin
            head_imm <= dec_imm;
            head_err <= dec_err;
          end else if (i_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (i_ready) begin
            state    <= ONE;
            head_imm <= skid_imm;
            head_err <= skid_err;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state != EMPTY);
  assign o_imm     = head_imm;
  assign o_err     = head_err;
  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Directed bench for riscv_imm_gen_pipe: decode formats, skid-buffer handshake,
// error counter saturation and asynchronous reset; an XLEN=64 twin checks wide extension.
module tb_riscv_imm_gen_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instr;
  logic [2:0]  i_imm_src;
  logic        i_valid;
  logic        i_ready;

  logic        o_ready, o_err, o_valid;
  logic [31:0] o_imm;
  logic [7:0]  o_err_cnt;

  logic        w_ready, w_err, w_valid;
  logic [63:0] w_imm;
  logic [7:0]  w_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  riscv_imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_instr  (i_instr),
    .i_imm_src(i_imm_src),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_imm    (o_imm),
    .o_err    (o_err),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_err_cnt(o_err_cnt)
  );

  riscv_imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_dut64 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_instr  (i_instr),
    .i_imm_src(i_imm_src),
    .i_valid  (i_valid),
    .o_ready  (w_ready),
    .o_imm    (w_imm),
    .o_err    (w_err),
    .o_valid  (w_valid),
    .i_ready  (i_ready),
    .o_err_cnt(w_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic step(input logic [31:0] instr, input logic [2:0] src,
                      input logic valid, input logic ready);
    i_instr   = instr;
    i_imm_src = src;
    i_valid   = valid;
    i_ready   = ready;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_instr = '0; i_imm_src = '0; i_valid = 1'b0; i_ready = 1'b0;
    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_imm",   64'(o_imm),   64'd0);
    check("rst_cnt",   64'(o_err_cnt), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("ready_after_rst", 64'(o_ready), 64'd1);
    check("idle_valid",      64'(o_valid), 64'd0);

    // Single I-type beat, 1-cycle latency.
    step(32'hFFF00093, 3'd0, 1'b1, 1'b1);
    check("i_valid", 64'(o_valid), 64'd1);
    check("i_imm",   64'(o_imm),   64'hFFFF_FFFF);
    check("i_err",   64'(o_err),   64'd0);
    check("i_imm64", w_imm,        64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back S, B, U.
    step(32'hFE112E23, 3'd1, 1'b1, 1'b1);
    check("s_imm", 64'(o_imm), 64'hFFFF_FFFC);
    step(32'hFE000EE3, 3'd2, 1'b1, 1'b1);
    check("b_imm", 64'(o_imm), 64'hFFFF_FFFC);
    step(32'h123450B7, 3'd3, 1'b1, 1'b1);
    check("u_imm",   64'(o_imm), 64'h1234_5000);
    check("u_valid", 64'(o_valid), 64'd1);

    // U with bit 31 set: sign-extends above bit 31 only on the wide twin.
    step(32'h800000B7, 3'd3, 1'b1, 1'b1);
    check("u_neg",   64'(o_imm), 64'h8000_0000);
    check("u_neg64", w_imm,      64'hFFFF_FFFF_8000_0000);

    // SHAMT width differs by XLEN.
    step(32'h03F01013, 3'd5, 1'b1, 1'b1);
    check("shamt32", 64'(o_imm), 64'h1F);
    check("shamt64", w_imm,      64'h3F);

    // Drain to EMPTY.
    step(32'h0, 3'd0, 1'b0, 1'b1);
    check("drain_valid", 64'(o_valid), 64'd0);

    // Stall: A (I=5), B (J=8) accepted, C (ZIMM=0x1F) held upstream.
    step(32'h00500093, 3'd0, 1'b1, 1'b0);
    check("stall_a_imm",   64'(o_imm),   64'd5);
    check("stall_a_ready", 64'(o_ready), 64'd1);
    step(32'h0080006F, 3'd4, 1'b1, 1'b0);
    check("full_ready", 64'(o_ready), 64'd0);
    check("full_imm",   64'(o_imm),   64'd5);
    step(32'h000F8000, 3'd6, 1'b1, 1'b0);
    check("hold_imm",   64'(o_imm),   64'd5);
    check("hold_ready", 64'(o_ready), 64'd0);
    check("hold_valid", 64'(o_valid), 64'd1);
    step(32'h000F8000, 3'd6, 1'b1, 1'b1);
    check("drain_b_imm",   64'(o_imm),   64'd8);
    check("drain_b_ready", 64'(o_ready), 64'd1);
    step(32'h000F8000, 3'd6, 1'b1, 1'b1);
    check("drain_c_imm", 64'(o_imm), 64'h1F);
    check("drain_c_err", 64'(o_err), 64'd0);
    step(32'hFFFF_FFFF, 3'd7, 1'b0, 1'b1);
    check("drained_valid", 64'(o_valid), 64'd0);
    check("ignored_cnt",   64'(o_err_cnt), 64'd0);

    // Illegal select: counter saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      step(32'hFFFF_FFFF, 3'd7, 1'b1, 1'b1);
      if (k == 1 || k == 254 || k == 255 || k == 300) begin
        check($sformatf("err_cnt_%0d", k), 64'(o_err_cnt), 64'(k > 255 ? 255 : k));
        check($sformatf("err_flag_%0d", k), 64'(o_err), 64'd1);
        check($sformatf("err_imm_%0d", k), 64'(o_imm), 64'd0);
      end
    end
    step(32'h00500093, 3'd0, 1'b1, 1'b1);
    check("err_clear", 64'(o_err), 64'd0);
    check("cnt_sticky", 64'(o_err_cnt), 64'd255);

    // Fill, then reset asynchronously mid-cycle.
    step(32'h0, 3'd0, 1'b0, 1'b1);
    step(32'h00700093, 3'd0, 1'b1, 1'b0);
    step(32'h00900093, 3'd0, 1'b1, 1'b0);
    check("pre_rst_ready", 64'(o_ready), 64'd0);
    #2 i_rst = 1'b1;
    #1;
    check("arst_valid", 64'(o_valid),   64'd0);
    check("arst_cnt",   64'(o_err_cnt), 64'd0);
    check("arst_imm",   64'(o_imm),     64'd0);
    check("arst_ready", 64'(o_ready),   64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("post_rst_ready", 64'(o_ready), 64'd1);
    check("post_rst_valid", 64'(o_valid), 64'd0);
    step(32'h00300093, 3'd0, 1'b1, 1'b1);
    check("fresh_imm", 64'(o_imm), 64'd3);
    step(32'h0, 3'd0, 1'b0, 1'b1);
    check("no_stale", 64'(o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
